// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the UART transmit controller.
package uart_pkg;

  localparam int OSM16_DEF = 16;
  localparam int OSM13_DEF = 13;
  localparam int CNT_W     = 5;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Line-control fields captured when a frame is loaded.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       osm;
  } frame_cfg_t;

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - wls);
    x    = ^(data & mask);
    if (sp) begin
      parity_bit = ~eps;
    end else if (eps) begin
      parity_bit = x;
    end else begin
      parity_bit = ~x;
    end
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_bit_timer.sv
// Oversample tick counter; reports the last tick of a full bit and of a half bit.
import uart_pkg::*;

module uart_bit_timer (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             tick_in,
  input  logic             clear_in,
  input  logic [CNT_W-1:0] n_in,
  input  logic             half_in,
  output logic             full_tc_out,
  output logic             half_tc_out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half_n_s;
  logic             wrap_s;

  // Half bit is ceil(N/2) ticks; the counter wraps at whichever terminal is active.
  always_comb begin
    half_n_s    = (n_in + {{(CNT_W-1){1'b0}}, 1'b1}) >> 1;
    full_tc_out = tick_in && (cnt_q == (n_in - {{(CNT_W-1){1'b0}}, 1'b1}));
    half_tc_out = tick_in && (cnt_q == (half_n_s - {{(CNT_W-1){1'b0}}, 1'b1}));
    wrap_s      = half_in ? half_tc_out : full_tc_out;
    cnt_d       = cnt_q;
    if (clear_in) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick_in) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: THR -> TSR frame sequencer with 16550-style framing and status.
import uart_pkg::*;

module uart_tx_ctrl #(
  parameter int OSM16 = OSM16_DEF,
  parameter int OSM13 = OSM13_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic       enable_in,
  input  logic       thr_wr_in,
  input  logic [7:0] thr_in,
  input  logic [1:0] wls_in,
  input  logic       stb_in,
  input  logic       pen_in,
  input  logic       eps_in,
  input  logic       sp_in,
  input  logic       bc_in,
  input  logic       osm_sel_in,
  output logic       serial_out,
  output logic       thre_out,
  output logic       temt_out,
  output logic       thre_pulse_out,
  output logic       wr_err_out
);

  localparam logic [CNT_W-1:0] N16_C = CNT_W'(OSM16);
  localparam logic [CNT_W-1:0] N13_C = CNT_W'(OSM13);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic [7:0] tsr_q, tsr_d;
  frame_cfg_t cfg_q, cfg_d;
  logic       serial_q, serial_d;
  logic       thre_q, thre_d;
  logic       temt_q, temt_d;
  logic       pulse_q, pulse_d;
  logic       wr_err_q, wr_err_d;

  frame_cfg_t       cfg_in_s;
  logic             load_s;
  logic             half_mode_s;
  logic             bit_end_s;
  logic             full_tc_s;
  logic             half_tc_s;
  logic             timer_clr_s;
  logic [2:0]       last_bit_s;
  logic [CNT_W-1:0] n_s;
  logic             line_s;

  uart_bit_timer u_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tick_in     (tick_in),
    .clear_in    (timer_clr_s),
    .n_in        (n_s),
    .half_in     (half_mode_s),
    .full_tc_out (full_tc_s),
    .half_tc_out (half_tc_s)
  );

  // Frame-level control terms derived from the current state and latched framing.
  always_comb begin
    cfg_in_s    = '{wls: wls_in, stb: stb_in, pen: pen_in, eps: eps_in, sp: sp_in, osm: osm_sel_in};
    load_s      = (state_q == ST_IDLE) && thr_full_q && enable_in;
    n_s         = cfg_q.osm ? N13_C : N16_C;
    half_mode_s = (state_q == ST_STOP) && (bit_q == 3'd1) && cfg_q.stb && (cfg_q.wls == WLS_5);
    bit_end_s   = half_mode_s ? half_tc_s : full_tc_s;
    timer_clr_s = (!enable_in) || (state_q == ST_IDLE);
    last_bit_s  = 3'd4 + {1'b0, cfg_q.wls};
  end

  // Next-state, holding-register and output logic.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    tsr_d    = tsr_q;
    cfg_d    = cfg_q;
    thr_d    = thr_q;
    thr_full_d = thr_full_q;
    wr_err_d = 1'b0;
    line_s   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          tsr_d   = thr_q;
          cfg_d   = cfg_in_s;
          bit_d   = 3'd0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_q == last_bit_s)) begin
          bit_d   = 3'd0;
          state_d = cfg_q.pen ? ST_PARITY : ST_STOP;
        end else if (bit_end_s) begin
          bit_d   = bit_q + 3'd1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          bit_d   = 3'd0;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        // bit_q counts stop bits; a second (full or half) bit follows when stb is set.
        if (bit_end_s && cfg_q.stb && (bit_q == 3'd0)) begin
          bit_d = 3'd1;
        end else if (bit_end_s) begin
          bit_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        bit_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase

    if (!enable_in) begin
      bit_d   = 3'd0;
      state_d = ST_IDLE;
    end else begin
      bit_d   = bit_d;
    end

    // A write in the transfer cycle lands after the old byte has moved to the TSR.
    if (thr_wr_in && (!thr_full_q || load_s)) begin
      thr_d      = thr_in;
      thr_full_d = 1'b1;
    end else if (thr_wr_in) begin
      wr_err_d   = 1'b1;
    end else if (load_s) begin
      thr_full_d = 1'b0;
    end else begin
      thr_full_d = thr_full_q;
    end

    case (state_d)
      ST_IDLE:   line_s = 1'b1;
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = tsr_d[bit_d];
      ST_PARITY: line_s = parity_bit(tsr_d, cfg_d.wls, cfg_d.eps, cfg_d.sp);
      ST_STOP:   line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase

    serial_d = bc_in ? 1'b0 : line_s;
    thre_d   = !thr_full_d;
    temt_d   = thre_d && (state_d == ST_IDLE);
    pulse_d  = thr_full_q && !thr_full_d;
  end

  // State, data and registered output flops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      bit_q      <= 3'd0;
      thr_q      <= 8'd0;
      thr_full_q <= 1'b0;
      tsr_q      <= 8'd0;
      cfg_q      <= '0;
      serial_q   <= 1'b1;
      thre_q     <= 1'b1;
      temt_q     <= 1'b1;
      pulse_q    <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      tsr_q      <= tsr_d;
      cfg_q      <= cfg_d;
      serial_q   <= serial_d;
      thre_q     <= thre_d;
      temt_q     <= temt_d;
      pulse_q    <= pulse_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign serial_out     = serial_q;
  assign thre_out       = thre_q;
  assign temt_out       = temt_q;
  assign thre_pulse_out = pulse_q;
  assign wr_err_out     = wr_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a per-tick line-level scoreboard fed at write time.
module tb_uart_tx_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in, tick_in, enable_in, thr_wr_in;
  logic [7:0] thr_in;
  logic [1:0] wls_in;
  logic       stb_in, pen_in, eps_in, sp_in, bc_in, osm_sel_in;
  logic       serial_out, thre_out, temt_out, thre_pulse_out, wr_err_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];

  uart_tx_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tick_in        (tick_in),
    .enable_in      (enable_in),
    .thr_wr_in      (thr_wr_in),
    .thr_in         (thr_in),
    .wls_in         (wls_in),
    .stb_in         (stb_in),
    .pen_in         (pen_in),
    .eps_in         (eps_in),
    .sp_in          (sp_in),
    .bc_in          (bc_in),
    .osm_sel_in     (osm_sel_in),
    .serial_out     (serial_out),
    .thre_out       (thre_out),
    .temt_out       (temt_out),
    .thre_pulse_out (thre_pulse_out),
    .wr_err_out     (wr_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] wls, input logic stb, input logic pen,
                         input logic eps, input logic sp, input logic osm);
    wls_in = wls; stb_in = stb; pen_in = pen; eps_in = eps; sp_in = sp; osm_sel_in = osm;
  endtask

  // Expected line level before each tick of the frame, from the current framing inputs.
  task automatic push_frame(input logic [7:0] d);
    int   n, nb, ones, stop;
    logic par;
    n    = osm_sel_in ? 13 : 16;
    nb   = 5 + int'(wls_in);
    ones = 0;
    repeat (n) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      repeat (n) exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen_in) begin
      if (sp_in) par = ~eps_in;
      else       par = eps_in ? (ones % 2 == 1) : (ones % 2 == 0);
      repeat (n) exp_q.push_back(par);
    end
    if (!stb_in)             stop = n;
    else if (wls_in == 2'd0) stop = n + (n + 1) / 2;
    else                     stop = 2 * n;
    repeat (stop) exp_q.push_back(1'b1);
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    @(negedge clk_in);
    tick_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic run_ticks(input int k, input logic brk);
    logic lvl;
    for (int i = 0; i < k; i++) begin
      if (exp_q.size() == 0) break;
      lvl = exp_q.pop_front();
      if (brk) chk("line_break", serial_out, 1'b0);
      else     chk("line", serial_out, lvl);
      do_tick();
    end
  endtask

  task automatic finish_frame();
    while (exp_q.size() > 1) run_ticks(1, 1'b0);
    chk("temt_busy", temt_out, 1'b0);
    run_ticks(1, 1'b0);
    chk("temt_done", temt_out, 1'b1);
    chk("line_idle", serial_out, 1'b1);
  endtask

  task automatic wr(input logic [7:0] d);
    thr_in    = d;
    thr_wr_in = 1'b1;
    @(negedge clk_in);
    thr_wr_in = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] d);
    push_frame(d);
    wr(d);
    chk("thre_after_wr", thre_out, 1'b0);
    chk("pulse_before_load", thre_pulse_out, 1'b0);
    @(negedge clk_in);
    chk("thre_after_load", thre_out, 1'b1);
    chk("thre_pulse", thre_pulse_out, 1'b1);
    chk("start_bit", serial_out, 1'b0);
    chk("temt_load", temt_out, 1'b0);
    @(negedge clk_in);
    chk("pulse_one_cycle", thre_pulse_out, 1'b0);
  endtask

  initial begin
    rst_in = 1'b1; tick_in = 1'b0; enable_in = 1'b1; thr_wr_in = 1'b0; thr_in = 8'h00;
    bc_in = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_in);
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_thre", thre_out, 1'b1);
    chk("rst_temt", temt_out, 1'b1);
    chk("rst_pulse", thre_pulse_out, 1'b0);
    chk("rst_wr_err", wr_err_out, 1'b0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // 8N1 at 16x; framing inputs are scrambled after load and must not matter.
    start_frame(8'hA5);
    set_cfg(2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    finish_frame();

    // 7E1, 7O1 and stick parity on 0x35.
    set_cfg(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    start_frame(8'h35);
    finish_frame();
    set_cfg(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_frame(8'h35);
    finish_frame();
    set_cfg(2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    start_frame(8'h35);
    finish_frame();

    // 5 data bits, 1.5 stop at 13x; then 6O2 at 16x.
    set_cfg(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    start_frame(8'h15);
    finish_frame();
    set_cfg(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    start_frame(8'h2C);
    finish_frame();

    // Back-to-back frames with a rejected third write.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(8'h11);
    run_ticks(3, 1'b0);
    wr(8'h22);
    chk("thre_b2b", thre_out, 1'b0);
    chk("wr_err_accept", wr_err_out, 1'b0);
    push_frame(8'h22);
    wr(8'h33);
    chk("wr_err", wr_err_out, 1'b1);
    @(negedge clk_in);
    chk("wr_err_clr", wr_err_out, 1'b0);
    chk("thre_still_full", thre_out, 1'b0);
    finish_frame();

    // Reset during DATA bit 3 with a byte waiting in the THR.
    start_frame(8'hC3);
    run_ticks(16 + 3 * 16 + 5, 1'b0);
    wr(8'h77);
    chk("thre_pre_rst", thre_out, 1'b0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_serial", serial_out, 1'b1);
    chk("midrst_thre", thre_out, 1'b1);
    chk("midrst_temt", temt_out, 1'b1);
    rst_in = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    start_frame(8'h5A);
    finish_frame();

    // Break held across a bit boundary, then released.
    start_frame(8'hA5);
    run_ticks(24, 1'b0);
    bc_in = 1'b1;
    @(negedge clk_in);
    run_ticks(16, 1'b1);
    bc_in = 1'b0;
    @(negedge clk_in);
    finish_frame();

    // Disable mid-frame with the THR full, then re-enable.
    start_frame(8'h3C);
    run_ticks(30, 1'b0);
    wr(8'h99);
    enable_in = 1'b0;
    @(negedge clk_in);
    chk("dis_serial", serial_out, 1'b1);
    chk("dis_thre", thre_out, 1'b0);
    chk("dis_temt", temt_out, 1'b0);
    repeat (3) do_tick();
    chk("dis_serial_hold", serial_out, 1'b1);
    chk("dis_thre_hold", thre_out, 1'b0);
    exp_q.delete();
    push_frame(8'h99);
    enable_in = 1'b1;
    @(negedge clk_in);
    chk("reen_pulse", thre_pulse_out, 1'b1);
    chk("reen_start", serial_out, 1'b0);
    chk("reen_thre", thre_out, 1'b1);
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame at a time from a single-entry transmit holding register (THR) through an internal transmit shift register (TSR). It runs on the system clock and advances on an external oversample tick. Framing is set by 16550-style line-control fields: word length, parity, stop bits and break. It sits between the register-file write path and the `serial_out` pin, and reports holding-register and transmitter-empty status back to the register and interrupt logic.

## Interface
- `OSM16`, default 16: oversample ticks per bit when `osm_sel_in`=0.
- `OSM13`, default 13: oversample ticks per bit when `osm_sel_in`=1.
- `clk_in` input 1: system clock; all logic is on the rising edge.
- `rst_in` input 1: reset, synchronous and active-high.
- `tick_in` input 1: oversample strobe, one `clk_in` cycle wide.
- `enable_in` input 1: transmitter enable.
- `thr_wr_in` input 1: THR write strobe.
- `thr_in` input 8: THR write data.
- `wls_in` input 2: word length, 0..3 selects 5..8 data bits.
- `stb_in` input 1: stop-bit select; 0 gives 1 stop bit, 1 gives 1.5 stop bits (5-bit words) or 2 stop bits (otherwise).
- `pen_in` input 1: parity enable.
- `eps_in` input 1: even parity select.
- `sp_in` input 1: stick parity.
- `bc_in` input 1: break control.
- `osm_sel_in` input 1: oversample-rate select.
- `serial_out` output 1: TX line, registered.
- `thre_out` output 1: THR empty.
- `temt_out` output 1: THR and TSR both empty.
- `thre_pulse_out` output 1: one-cycle pulse when `thre_out` rises.
- `wr_err_out` output 1: one-cycle pulse when a write is rejected.

## Operation
- **Reset values:** `serial_out`=1, `thre_out`=1, `temt_out`=1, `thre_pulse_out`=0, `wr_err_out`=0. State is IDLE and all counters are 0.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Bit timing:** the tick counter increments on `tick_in`. A bit ends on the tick where the counter equals N-1; the counter then returns to 0.
  - N = `OSM16` or `OSM13`, latched at frame load.
  - Half stop bit = ceil(N/2): 8 ticks at 16x, 7 ticks at 13x.
- **IDLE:** `serial_out`=1. If THR is full and `enable_in`=1:
  - THR moves to TSR and THR becomes empty.
  - `wls_in`, `stb_in`, `pen_in`, `eps_in`, `sp_in` and `osm_sel_in` are latched.
  - State goes to START. Later changes to these inputs do not affect the frame in progress.
- **START:** `serial_out`=0 for one bit, then DATA.
- **DATA:** sends TSR LSB-first, 5+`wls` bits. Then PARITY if `pen_in` was latched as 1, otherwise STOP.
- **PARITY:** one bit, value set by the latched fields:
  - sp=1: bit is ~eps.
  - sp=0, eps=1 (even): bit is XOR of the data bits.
  - sp=0, eps=0 (odd): bit is the inverted XOR of the data bits.
  - Bits above the word length are excluded.
- **STOP:** `serial_out`=1 for 1, 1.5 or 2 bits, then IDLE.
  - If THR is full at the end of STOP, the next load happens on the IDLE cycle that follows, so back-to-back frames have no idle bit.
- **THR write:**
  - Accepted when the THR is empty, or when it is full and being transferred in the same cycle; the transfer happens first.
  - Otherwise the write is discarded, the THR is unchanged and `wr_err_out` pulses.
- **Status:** `temt_out` = `thre_out` AND state==IDLE.
- **`enable_in`=0:** state is forced to IDLE on the next edge. The frame is aborted, `serial_out`=1, the THR is retained and the tick counter is cleared.
- **`bc_in`=1:** `serial_out` is forced to 0. Sequencing continues unchanged underneath.
- **`rst_in` mid-frame:** all reset values apply on the next edge and the THR contents are lost.

## Timing
- `thr_wr_in` sampled at edge e0 with IDLE and `enable_in`=1:
  - after e0: `thre_out`=0.
  - after e1: THR transferred to TSR, `thre_out`=1, `thre_pulse_out`=1 for one cycle, `serial_out`=0.
- `serial_out` changes on the edge that consumes the last tick of a bit.
- Frame length in ticks = N×(1 + data bits + parity) + stop ticks.
  - 8N1 at 16x: 160 ticks.
  - 5N1.5 at 16x: 16×6 + 24 = 120 ticks.
- `tick_in` is ignored in IDLE.

## Structure
- Package `uart_pkg` holds:
  - the state enum;
  - the WLS codes;
  - the OSM16/OSM13 constants;
  - a parity function of (data, wls, eps, sp).
- Sub-module `uart_bit_timer` holds the tick counter with load, clear and a terminal-count output (full bit and half bit).
- The FSM, THR, TSR and bit counter stay in `uart_tx_ctrl`.

## Test plan
- **8N1, 16x:** write 0xA5 → `serial_out` is 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; `temt_out` returns to 1 after 160 ticks.
- **Parity:**
  - 7E1, write 0x35 → parity bit 0.
  - Same data with `eps_in`=0 → parity bit 1.
  - `sp_in`=1 with `eps_in`=1 → parity bit 0.
- **5-bit words, `stb_in`=1, 13x:** stop high for 20 ticks; total frame 98 ticks.
- **Back-to-back and rejected write:**
  - Write 0x11, then 0x22 during START → no idle gap between the frames.
  - A third write while the THR is full → `wr_err_out` pulses and 0x22 is still sent unchanged.
- **Reset mid-frame:** `rst_in` asserted during DATA bit 3 → next cycle `serial_out`=1, `thre_out`=1, `temt_out`=1; a new write transmits cleanly.
- **Break and disable:**
  - `bc_in`=1 mid-frame → line low; on release, the line resumes the current bit value.
  - `enable_in`=0 mid-frame → IDLE and line high; re-enable → the THR byte is sent.
